freq_meter: RTL
===============

// Module: freq_meter
// PURPOSE
//  Measures the frequency of the square-wave test signal sigin, which the test-signal generator
//  produces from sysclk at 50 Hz, 3125 Hz, 6250 Hz or 12500 Hz.
//  Counts rising edges of sigin over a fixed gate window of sysclk cycles, then latches the count.
//  Converts the latched count to 5-digit BCD with a sequential shift-add-3 engine for the display stage.
//  Windows run back-to-back; conversion of window N overlaps counting of window N+1.
// PARAMETERS
//  GATE_CYCLES  100_000_000  gate window length in sysclk cycles (1 s at 100 MHz, so count = Hz)
//  CNT_W        17           width of the edge counter and of freq_bin
//  MAX_COUNT    99999        saturation value; the largest count 5 BCD digits can show
// PORTS
//  sysclk    in   1      system clock, 100 MHz
//  reset     in   1      asynchronous, active-high reset
//  sigin     in   1      signal under test, asynchronous to sysclk
//  freq_bin  out  CNT_W  rising edges counted in the last completed window, saturated
//  freq_bcd  out  20     freq_bin as BCD, digit 4 in [19:16] down to digit 0 in [3:0]
//  overflow  out  1      last completed window saturated at MAX_COUNT
//  valid     out  1      one-cycle pulse when freq_bcd/overflow update
//  busy      out  1      BCD conversion in progress
// BEHAVIOUR
//  Reset: freq_bin=0, freq_bcd=0, overflow=0, valid=0, busy=0; all counters and synchronizer flops=0.
//  On release the FSM is in CONV_IDLE and the gate window starts at gate_cnt=0.
//  Input path: 2-flop synchronizer s1->s2, plus a delayed copy s3. An edge is counted in a cycle where
//   s2=1 and s3=0. That cycle is 3 sysclk after the sigin transition at most.
//  Gate: gate_cnt runs 0..GATE_CYCLES-1 and wraps to 0 with no dead cycle.
//  End-of-window cycle T is the cycle where gate_cnt==GATE_CYCLES-1.
//   - Window total = edge_cnt plus the edge detected in cycle T, if any.
//   - At T+1: freq_bin = min(total, MAX_COUNT) and overflow_pend = (total > MAX_COUNT).
//   - At T+1: edge_cnt = 0. An edge detected in cycle T is not carried into the next window.
//  Edge counter saturates at MAX_COUNT+1 and never wraps.
//  Conversion FSM states and transitions:
//   - CONV_IDLE -> SHIFT at T+1: loads shift reg with the new freq_bin and clears the BCD accumulator; busy=1.
//   - SHIFT: 17 iterations, cycles T+1..T+17. Each cycle: add 3 to every BCD digit >=5, then shift
//     left 1, with the binary MSB entering the BCD LSB.
//   - SHIFT -> DONE after iteration 17. DONE, at T+18: freq_bcd = accumulator, overflow = overflow_pend,
//     valid=1 for exactly this cycle, busy=0.
//   - DONE -> CONV_IDLE next cycle.
//  freq_bcd and overflow hold between valid pulses. freq_bin changes at T+1, before freq_bcd changes.
//  Conversion needs GATE_CYCLES >= 20. A window end while busy cannot occur and needs no handling.
//  Reset asserted mid-window or mid-conversion: everything clears immediately. No valid pulse is
//   produced for the aborted window. The first window after release measures a full GATE_CYCLES.
//  sigin stuck high or low: the next window gives total=0, so freq_bcd=0 and valid still pulses.
// TESTING
//  (all use GATE_CYCLES=1000)
//  1. sigin period 10 cycles -> each valid: freq_bin=100, freq_bcd=20'h00100, overflow=0. Consecutive valid pulses 1000 cycles apart.
//  2. sigin held 0 -> valid at cycle 1018 after reset release, freq_bcd=0. Later windows also give 0.
//  3. GATE_CYCLES=250_000, CNT_W=17, sigin period 2 cycles -> total 125000 > 99999:
//     freq_bin=99999, freq_bcd=20'h99999, overflow=1.
//  4. Edge placed so it is detected exactly in cycle T (gate_cnt==999) -> counted in the ending window only; the next window excludes it.
//  5. Assert reset at gate_cnt=500 and again during SHIFT -> outputs 0 immediately, no valid pulse.
//     First valid arrives 1018 cycles after release.
//  6. Period switched from 10 to 40 cycles mid-window -> that window reports an intermediate count (exact value from bench model).
//     Next window reports freq_bcd=20'h00025.

Source files
------------

// File: rtl/freq_meter.sv
// freq_meter: frequency meter for a square-wave test signal.
//   Counts rising edges of sigin over a gate window of GATE_CYCLES sysclk
//   cycles, latches the saturated count, then converts it to 5-digit BCD
//   with a sequential shift-add-3 engine while the next window counts.
// Ports:
//   sysclk   - system clock
//   reset    - asynchronous, active-high reset
//   sigin    - signal under test, asynchronous to sysclk
//   freq_bin - saturated edge count of the last completed window
//   freq_bcd - freq_bin as BCD, digit 4 in [19:16] .. digit 0 in [3:0]
//   overflow - last completed window saturated at MAX_COUNT
//   valid    - one-cycle pulse when freq_bcd/overflow update
//   busy     - BCD conversion in progress
module freq_meter #(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int CNT_W       = 17,
  parameter int MAX_COUNT   = 99999
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             sigin,
  output logic [CNT_W-1:0] freq_bin,
  output logic [19:0]      freq_bcd,
  output logic             overflow,
  output logic             valid,
  output logic             busy
);
  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int IW = $clog2(CNT_W + 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] SAT_C = CNT_W'(MAX_COUNT + 1);

  typedef enum logic [1:0] {CONV_IDLE, SHIFT, DONE} state_t;

  logic             s1, s2, s3;
  logic             edge_det;
  logic [GW-1:0]    gate_cnt;
  logic             win_end;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W:0]   total;
  logic [CNT_W-1:0] total_sat;
  logic             ovf_pend;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] shreg;
  logic [19:0]      acc, acc_adj, acc_nxt;
  logic [IW-1:0]    iter;

  // Input synchronizer plus one delay stage for rising-edge detection.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sigin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det = s2 & ~s3;
  assign win_end  = (gate_cnt == GW'(GATE_CYCLES - 1));

  // An edge seen in the last gate cycle belongs to the ending window.
  assign total     = {1'b0, edge_cnt} + (CNT_W + 1)'(edge_det);
  assign total_sat = (total > {1'b0, MAX_C}) ? MAX_C : total[CNT_W-1:0];

  // Gate window, edge counter and binary result latch.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      freq_bin <= '0;
      ovf_pend <= 1'b0;
    end else begin
      gate_cnt <= win_end ? '0 : gate_cnt + 1'b1;
      if (win_end) begin
        edge_cnt <= '0;
        freq_bin <= total_sat;
        ovf_pend <= (total > {1'b0, MAX_C});
      end else if (edge_det && edge_cnt != SAT_C) begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

  // Shift-add-3: bias each digit >= 5 before the shift so it carries correctly.
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < 5; d++) begin
      if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
    acc_nxt = (acc_adj << 1) | 20'(shreg[CNT_W-1]);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state <= CONV_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CONV_IDLE: if (win_end) state_nxt = SHIFT;
      SHIFT:     if (iter == IW'(CNT_W - 1)) state_nxt = DONE;
      DONE:      state_nxt = CONV_IDLE;
      default:   state_nxt = CONV_IDLE;
    endcase
  end

  // Conversion datapath; results are published on the last iteration so
  // they appear together with the DONE state.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      acc      <= '0;
      iter     <= '0;
      freq_bcd <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        CONV_IDLE: begin
          if (win_end) begin
            shreg <= total_sat;
            acc   <= '0;
            iter  <= '0;
          end
        end
        SHIFT: begin
          acc   <= acc_nxt;
          shreg <= shreg << 1;
          iter  <= iter + 1'b1;
          if (iter == IW'(CNT_W - 1)) begin
            freq_bcd <= acc_nxt;
            overflow <= ovf_pend;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (state == DONE);
  assign busy  = (state == SHIFT);
endmodule
